// File: rtl/aes_pkg.sv
// Shared AES decrypt helpers: column-major state mapping, GF(2^8) xtime,
// InvShiftRows and single-column InvMixColumns.
package aes_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    function automatic int byte_idx(input int row, input int col);
        return row + 4 * col;
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < 4; r++)
                res[8*byte_idx(r, c) +: 8] = s[8*byte_idx(r, (c - r + 4) % 4) +: 8];
        return res;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2    = gf_xtime(a[i]);
            x4    = gf_xtime(x2);
            x8    = gf_xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = me[i] ^ mb[2'(i + 1)] ^ md[2'(i + 2)] ^ m9[2'(i + 3)];
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_inv_byte_sub.sv
// Combinational AES inverse S-box (FIPS-197), one byte.
module inv_byte_sub (
    input  logic [7:0] data,
    output logic [7:0] result
);
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign result = INV_SBOX[data];
endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched via key_idx.
// Define AES_INV_ZEROIZE_EN to clear state_reg/out_data after the output handshake.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter int KEY_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [127:0]         round_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 busy
);
    fsm_t                 fsm, fsm_nxt;
    logic [KEY_IDX_W-1:0] rnd;
    logic [127:0]         state_reg;
    logic [15:0][7:0]     shifted, subbed;
    logic [127:0]         added, mixed;

    assign shifted = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_sub
        inv_byte_sub u_sub (
            .data   (shifted[i]),
            .result (subbed[i])
        );
    end

    assign added = subbed ^ round_key;

    for (genvar c = 0; c < NB; c++) begin : g_mix
        assign mixed[32*c +: 32] = inv_mix_column(added[32*c +: 32]);
    end

    always_comb begin
        fsm_nxt  = fsm;
        in_ready = 1'b0;
        busy     = 1'b0;
        key_idx  = '0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                key_idx  = KEY_IDX_W'(NR);
                if (in_valid) fsm_nxt = ROUND;
            end
            ROUND: begin
                busy    = 1'b1;
                key_idx = rnd;
                if (rnd == KEY_IDX_W'(1)) fsm_nxt = FINAL;
            end
            FINAL: begin
                busy    = 1'b1;
                fsm_nxt = DONE;
            end
            DONE: begin
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            fsm <= fsm_nxt;
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ round_key;
                        rnd       <= KEY_IDX_W'(NR - 1);
                    end
                end
                ROUND: begin
                    state_reg <= mixed;
                    rnd       <= rnd - KEY_IDX_W'(1);
                end
                FINAL: begin
                    out_data  <= added;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef AES_INV_ZEROIZE_EN
                        state_reg <= '0;
                        out_data  <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors plus random blocks against a byte-level model.
module tb_aes_inv_cipher;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         iv, ir, ov, ordy, bsy;
    logic [127:0] idat, odat, rkey;
    logic [3:0]   kidx;
    logic         iv14, ir14, ov14, ordy14, bsy14;
    logic [127:0] idat14, odat14, rkey14;
    logic [3:0]   kidx14;

    logic [127:0] rk10 [16];
    logic [127:0] rk14 [16];
    logic [127:0] rk_work [16];
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [7:0]   wb [240];
    logic [3:0]   ks [12];

    int n_chk = 0;
    int n_pass = 0;

    assign rkey   = rk10[kidx];
    assign rkey14 = rk14[kidx14];

    aes_inv_cipher #(.NR(10), .KEY_IDX_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in_data(idat),
        .key_idx(kidx), .round_key(rkey), .out_valid(ov), .out_ready(ordy),
        .out_data(odat), .busy(bsy)
    );

    aes_inv_cipher #(.NR(14), .KEY_IDX_W(4)) dut14 (
        .clk(clk), .reset(reset), .in_valid(iv14), .in_ready(ir14), .in_data(idat14),
        .key_idx(kidx14), .round_key(rkey14), .out_valid(ov14), .out_ready(ordy14),
        .out_data(odat14), .busy(bsy14)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x};
        return t[15-n -: 8];
    endfunction

    // Byte 0 of a FIPS hex string is its leftmost byte; the DUT wants it at [7:0].
    function automatic logic [127:0] to_vec(input logic [127:0] h);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = h[127-8*i -: 8];
        return v;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0)
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[a]  = s;
            isbox[s] = 8'(a);
        end
    endtask

    // Key is left-aligned in 256 bits, FIPS byte order.
    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        int nw = 4 * (nr + 1);
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 4*nk; i++) wb[i] = key[255-8*i -: 8];
        for (int i = nk; i < nw; i++) begin
            for (int k = 0; k < 4; k++) t[k] = wb[4*(i-1)+k];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = sbox[t[1]] ^ rc;
                t[1] = sbox[t[2]];
                t[2] = sbox[t[3]];
                t[3] = sbox[tmp];
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                for (int k = 0; k < 4; k++) t[k] = sbox[t[k]];
            end
            for (int k = 0; k < 4; k++) wb[4*i+k] = wb[4*(i-nk)+k] ^ t[k];
        end
        for (int r = 0; r < 16; r++) begin
            rk_work[r] = '0;
            if (r <= nr)
                for (int j = 0; j < 16; j++) rk_work[r][8*j +: 8] = wb[16*r+j];
        end
    endtask

    task automatic load10(input logic [127:0] key);
        expand({key, 128'h0}, 4, 10);
        for (int r = 0; r < 16; r++) rk10[r] = rk_work[r];
    endtask

    // FIPS-197 InvCipher on a byte array, AES-128 schedule in rk10.
    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] m [4];
        logic [127:0] res;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ rk10[10][8*i +: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w+4*c] = isbox[s[w + 4*((c - w + 4) % 4)]];
            for (int i = 0; i < 16; i++) t[i] ^= rk10[r][8*i +: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int w = 0; w < 4; w++) begin
                        s[w+4*c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[w+4*c] ^= gmul(m[(j - w + 4) % 4], t[j+4*c]);
                    end
            end else begin
                s = t;
            end
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    task automatic start10(input logic [127:0] ct);
        @(negedge clk);
        idat = ct;
        iv   = 1'b1;
        for (int i = 0; i < 60 && !ir; i++) @(negedge clk);
        chk("accept_ready", ir, 1'b1);
        ks[0] = kidx;
        @(negedge clk);
        iv = 1'b0;
    endtask

    // Entered at the first negedge after the accepting edge; lat = edges to out_valid.
    task automatic wait_out10(output int lat);
        for (lat = 0; lat < 40 && !ov; lat++) begin
            if (lat < 11) ks[lat+1] = kidx;
            @(negedge clk);
        end
        if (lat < 11) ks[lat+1] = kidx;
        chk("out_valid_seen", ov, 1'b1);
    endtask

    task automatic handshake10();
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
    endtask

    task automatic dec10(input logic [127:0] ct, input logic [127:0] exp, input string tag);
        int lat;
        start10(ct);
        wait_out10(lat);
        chk(tag, odat, exp);
        handshake10();
    endtask

    logic [127:0] c1_key, c1_ct, c1_pt, first, ct2, exp2;
    logic [47:0]  kv;
    int           lat, bad;

    initial begin
        reset = 1'b0; iv = 1'b0; ordy = 1'b0; idat = '0;
        iv14 = 1'b0; ordy14 = 1'b0; idat14 = '0;
        build_sbox();
        c1_key = 128'h000102030405060708090a0b0c0d0e0f;
        c1_ct  = to_vec(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        c1_pt  = to_vec(128'h00112233445566778899aabbccddeeff);
        load10(c1_key);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int r = 0; r < 16; r++) rk14[r] = rk_work[r];
        repeat (2) @(negedge clk);
        reset = 1'b1;

        chk("rst_out_valid", ov, 1'b0);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_in_ready", ir, 1'b1);
        chk("rst_out_data", odat, '0);
        chk("rst_key_idx", kidx, 4'd10);

        // FIPS-197 C.1 with latency and key_idx trace
        start10(c1_ct);
        wait_out10(lat);
        chk("c1_pt", odat, c1_pt);
        chk("c1_latency", lat, 10);
        for (int i = 0; i < 12; i++) kv[4*(11-i) +: 4] = ks[i];
        chk("key_idx_seq", kv, 48'ha98765432100);
        handshake10();
        chk("post_hs_valid", ov, 1'b0);
`ifdef AES_INV_ZEROIZE_EN
        chk("zeroized", odat, '0);
`else
        chk("held_pt", odat, c1_pt);
`endif

        // FIPS-197 App. B
        load10(128'h2b7e151628aed2a6abf7158809cf4f3c);
        dec10(to_vec(128'h3925841d02dc09fbdc118597196a0b32),
              to_vec(128'h3243f6a8885a308d313198a2e0370734), "appb_pt");

        // Backpressure with a held in_valid waiting behind the result
        load10(c1_key);
        ct2  = {$urandom, $urandom, $urandom, $urandom};
        exp2 = model_dec(ct2);
        start10(c1_ct);
        wait_out10(lat);
        first = odat;
        chk("bp_pt", first, c1_pt);
        idat = ct2;
        iv   = 1'b1;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (odat !== first || ir !== 1'b0 || bsy !== 1'b0 || ov !== 1'b1) bad++;
        end
        chk("bp_stable", bad, 0);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("bp_idle_ready", ir, 1'b1);
        chk("bp_valid_drop", ov, 1'b0);
        @(negedge clk);
        chk("bp_taken", bsy, 1'b1);
        iv = 1'b0;
        wait_out10(lat);
        chk("bp_pt2", odat, exp2);
        handshake10();

        // Reset while in ROUND with rnd==5
        start10(c1_ct);
        repeat (4) @(negedge clk);
        chk("mid_key_idx", kidx, 4'd5);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_valid", ov, 1'b0);
        chk("mid_rst_busy", bsy, 1'b0);
        chk("mid_rst_ready", ir, 1'b1);
        dec10(c1_ct, c1_pt, "post_rst_pt");

        // Random keys and ciphertexts against the model
        for (int n = 0; n < 6; n++) begin
            load10({$urandom, $urandom, $urandom, $urandom});
            ct2 = {$urandom, $urandom, $urandom, $urandom};
            dec10(ct2, model_dec(ct2), "rand_pt");
        end

        // NR=14, FIPS-197 C.3
        @(negedge clk);
        idat14 = to_vec(128'h8ea2b7ca516745bfeafc49904b496089);
        iv14   = 1'b1;
        for (int i = 0; i < 60 && !ir14; i++) @(negedge clk);
        @(negedge clk);
        iv14 = 1'b0;
        for (lat = 0; lat < 40 && !ov14; lat++) @(negedge clk);
        chk("c3_pt", odat14, to_vec(128'h00112233445566778899aabbccddeeff));
        chk("c3_latency", lat, 14);
        ordy14 = 1'b1;
        @(negedge clk);
        ordy14 = 1'b0;
        chk("c3_idle", {bsy14, ov14, ir14}, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
